// File: rtl/shared_mem_pkg.sv
// Shared definitions for the shared memory port: FSM state and owner encodings,
// plus the default geometry used by the port and its timeout counter.
package shared_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_1    = 2'd1,
        OWN_2    = 2'd2
    } owner_t;

    localparam int AW_DEF      = 8;
    localparam int DW_DEF      = 16;
    localparam int TIMEOUT_DEF = 16;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Saturating WAIT-cycle counter. expired is high once the count reaches
// TIMEOUT-1; the count then holds there until cleared.
module mem_timeout_cnt
    import shared_mem_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int             CW   = $clog2(TIMEOUT);
    localparam logic [CW-1:0]  LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    // Count enabled cycles, clear on request, stop at the last value instead of wrapping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != LAST)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == LAST);

endmodule

// File: rtl/shared_mem_port.sv
// Single shared memory port behind the two-core lock arbiter. Runs one
// transaction at a time for the granted core and feeds hold_1/hold_2 back to
// the arbiter so the lock stays put until the owner's access is acknowledged.
module shared_mem_port
    import shared_mem_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          grant_1,
    input  logic          grant_2,
    output logic          hold_1,
    output logic          hold_2,
    input  logic          req_1,
    input  logic          we_1,
    input  logic [AW-1:0] addr_1,
    input  logic [DW-1:0] wdata_1,
    output logic          ack_1,
    output logic          err_1,
    output logic [DW-1:0] rdata_1,
    input  logic          req_2,
    input  logic          we_2,
    input  logic [AW-1:0] addr_2,
    input  logic [DW-1:0] wdata_2,
    output logic          ack_2,
    output logic          err_2,
    output logic [DW-1:0] rdata_2,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_rdy,
    input  logic [DW-1:0] mem_rdata
);

    state_t  state;
    owner_t  owner;
    logic    cnt_clr;
    logic    cnt_en;
    logic    expired;
    logic    finish;
    logic [DW-1:0] cap_data;

    // The counter restarts in ISSUE and only advances while still waiting on memory
    assign cnt_clr  = (state == ISSUE);
    assign cnt_en   = (state == WAIT) && !mem_rdy;

    // A WAIT cycle ends on memory completion or timeout; writes and timeouts return zero data
    assign finish   = mem_rdy || expired;
    assign cap_data = (mem_rdy && !mem_we) ? mem_rdata : '0;

    mem_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .expired (expired)
    );

    // Transaction FSM with owner latch, memory port registers and per-core completion registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            owner     <= OWN_NONE;
            hold_1    <= 1'b0;
            hold_2    <= 1'b0;
            ack_1     <= 1'b0;
            ack_2     <= 1'b0;
            err_1     <= 1'b0;
            err_2     <= 1'b0;
            rdata_1   <= '0;
            rdata_2   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            // The owner keeps its lock for the whole transaction even if it drops req
            hold_1 <= req_1 | ((owner == OWN_1) && (state != IDLE));
            hold_2 <= req_2 | ((owner == OWN_2) && (state != IDLE));

            case (state)
                IDLE: begin
                    // Core 1 takes priority if the arbiter ever asserts both grants
                    if (grant_1 && req_1) begin
                        owner     <= OWN_1;
                        mem_we    <= we_1;
                        mem_addr  <= addr_1;
                        mem_wdata <= wdata_1;
                        mem_en    <= 1'b1;
                        state     <= ISSUE;
                    end else if (grant_2 && req_2) begin
                        owner     <= OWN_2;
                        mem_we    <= we_2;
                        mem_addr  <= addr_2;
                        mem_wdata <= wdata_2;
                        mem_en    <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en <= 1'b0;
                    state  <= WAIT;
                end
                WAIT: begin
                    if (finish) begin
                        state <= DONE;
                        if (owner == OWN_1) begin
                            ack_1   <= 1'b1;
                            err_1   <= !mem_rdy;
                            rdata_1 <= cap_data;
                        end else if (owner == OWN_2) begin
                            ack_2   <= 1'b1;
                            err_2   <= !mem_rdy;
                            rdata_2 <= cap_data;
                        end
                    end
                end
                DONE: begin
                    ack_1 <= 1'b0;
                    ack_2 <= 1'b0;
                    err_1 <= 1'b0;
                    err_2 <= 1'b0;
                    owner <= OWN_NONE;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shared_mem_port.sv
// Directed bench for shared_mem_port: reset, read, contended write, timeout,
// grant drop during WAIT and reset during WAIT.
module tb_shared_mem_port;

    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          grant_1 = 1'b0, grant_2 = 1'b0;
    logic          hold_1, hold_2;
    logic          req_1 = 1'b0, we_1 = 1'b0;
    logic [AW-1:0] addr_1 = '0;
    logic [DW-1:0] wdata_1 = '0;
    logic          ack_1, err_1;
    logic [DW-1:0] rdata_1;
    logic          req_2 = 1'b0, we_2 = 1'b0;
    logic [AW-1:0] addr_2 = '0;
    logic [DW-1:0] wdata_2 = '0;
    logic          ack_2, err_2;
    logic [DW-1:0] rdata_2;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rdy = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    int checks   = 0;
    int failures = 0;

    shared_mem_port #(.AW(AW), .DW(DW), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .grant_1(grant_1), .grant_2(grant_2),
        .hold_1(hold_1), .hold_2(hold_2),
        .req_1(req_1), .we_1(we_1), .addr_1(addr_1), .wdata_1(wdata_1),
        .ack_1(ack_1), .err_1(err_1), .rdata_1(rdata_1),
        .req_2(req_2), .we_2(we_2), .addr_2(addr_2), .wdata_2(wdata_2),
        .ack_2(ack_2), .err_2(err_2), .rdata_2(rdata_2),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdy(mem_rdy), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_flags"}, {24'd0, hold_1, hold_2, ack_1, ack_2, err_1, err_2, mem_en, mem_we}, 32'd0);
        chk({tag, "_rdata"}, {rdata_1, rdata_2}, 32'd0);
        chk({tag, "_mem"},   {8'd0, mem_addr, mem_wdata}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int n;
        int en_extra;

        // 1. reset with random inputs, then release with no requests
        for (int i = 0; i < 4; i++) begin
            grant_1 = 1'($urandom); grant_2 = 1'($urandom);
            req_1 = 1'($urandom);   req_2 = 1'($urandom);
            we_1 = 1'($urandom);    we_2 = 1'($urandom);
            addr_1 = AW'($urandom); addr_2 = AW'($urandom);
            wdata_1 = DW'($urandom); wdata_2 = DW'($urandom);
            mem_rdy = 1'($urandom); mem_rdata = DW'($urandom);
            tick();
            chk_all_zero("reset");
        end
        grant_1 = 0; grant_2 = 0; req_1 = 0; req_2 = 0; we_1 = 0; we_2 = 0;
        mem_rdy = 0;
        rst = 1'b1;
        tick();
        tick();
        chk_all_zero("idle_after_reset");

        // 2. core 1 read, memory ready in first WAIT cycle
        grant_1 = 1; req_1 = 1; addr_1 = 8'h3C; we_1 = 0;
        tick();
        chk("rd_issue_en", mem_en, 1);
        chk("rd_issue_addr", mem_addr, 32'h3C);
        chk("rd_issue_we", mem_we, 0);
        chk("rd_hold1_issue", hold_1, 1);
        mem_rdy = 1; mem_rdata = 16'hBEEF;
        tick();
        chk("rd_wait_en", mem_en, 0);
        chk("rd_wait_addr", mem_addr, 32'h3C);
        chk("rd_wait_ack", ack_1, 0);
        tick();
        chk("rd_ack1", ack_1, 1);
        chk("rd_err1", err_1, 0);
        chk("rd_rdata1", rdata_1, 32'hBEEF);
        chk("rd_ack2", ack_2, 0);
        chk("rd_hold1_done", hold_1, 1);
        mem_rdy = 0; req_1 = 0;
        tick();
        chk("rd_ack1_pulse", ack_1, 0);
        chk("rd_rdata1_held", rdata_1, 32'hBEEF);
        tick();
        chk("rd_hold1_released", hold_1, 0);

        // 3. core 2 write while both cores request; arbiter holds lock_2
        grant_1 = 0; grant_2 = 1; req_1 = 1; req_2 = 1;
        we_2 = 1; addr_2 = 8'h55; wdata_2 = 16'h1234;
        tick();
        chk("wr_issue_en", mem_en, 1);
        chk("wr_issue_we", mem_we, 1);
        chk("wr_issue_addr", mem_addr, 32'h55);
        chk("wr_issue_wdata", mem_wdata, 32'h1234);
        chk("wr_hold2_issue", hold_2, 1);
        tick();
        tick();
        chk("wr_hold2_wait", hold_2, 1);
        chk("wr_ack2_wait", ack_2, 0);
        mem_rdy = 1; mem_rdata = 16'hFFFF;
        tick();
        chk("wr_ack2", ack_2, 1);
        chk("wr_rdata2", rdata_2, 0);
        chk("wr_err2", err_2, 0);
        chk("wr_ack1", ack_1, 0);
        chk("wr_hold2_done", hold_2, 1);
        req_2 = 0; mem_rdy = 0;
        tick();
        chk("wr_no_core1_en_a", mem_en, 0);
        tick();
        chk("wr_no_core1_en_b", mem_en, 0);
        chk("wr_hold2_released", hold_2, 0);

        // 4. timeout on core 1: memory never ready
        grant_1 = 1; grant_2 = 0;
        tick();
        chk("to_issue_en", mem_en, 1);
        chk("to_issue_addr", mem_addr, 32'h3C);
        n = 0; en_extra = 0;
        do begin
            tick();
            n++;
            if (mem_en) en_extra++;
        end while (ack_1 !== 1'b1 && n < 40);
        chk("to_latency", n, 17);
        chk("to_err1", err_1, 1);
        chk("to_rdata1", rdata_1, 0);
        chk("to_ack2", ack_2, 0);
        chk("to_no_reissue", en_extra, 0);
        req_1 = 0;
        tick();
        chk("to_ack1_pulse", ack_1, 0);
        chk("to_err1_pulse", err_1, 0);

        // 5. grant dropped mid-WAIT, core 2 waiting
        req_1 = 1; addr_1 = 8'hA0; we_1 = 0;
        tick();
        chk("gd_issue_addr", mem_addr, 32'hA0);
        tick();
        grant_1 = 0; grant_2 = 1; req_2 = 1; addr_2 = 8'h66; we_2 = 0;
        tick();
        chk("gd_wait_en", mem_en, 0);
        mem_rdy = 1; mem_rdata = 16'hCAFE;
        tick();
        chk("gd_ack1", ack_1, 1);
        chk("gd_rdata1", rdata_1, 32'hCAFE);
        chk("gd_ack2", ack_2, 0);
        chk("gd_done_en", mem_en, 0);
        mem_rdy = 0; req_1 = 0;
        tick();
        chk("gd_idle_en", mem_en, 0);
        tick();
        chk("gd_core2_issue_en", mem_en, 1);
        chk("gd_core2_issue_addr", mem_addr, 32'h66);

        // 6. reset during WAIT, late mem_rdy, then a fresh transaction
        tick();
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        mem_rdy = 1; mem_rdata = 16'h5A5A; req_2 = 0;
        tick();
        rst = 1'b1;
        tick();
        chk("rst_late_ack2", ack_2, 0);
        chk("rst_late_en", mem_en, 0);
        tick();
        chk("rst_late_ack2_b", ack_2, 0);
        chk("rst_late_rdata2", rdata_2, 0);
        mem_rdy = 0; req_2 = 1; addr_2 = 8'h77; we_2 = 0;
        tick();
        chk("rst_fresh_en", mem_en, 1);
        chk("rst_fresh_addr", mem_addr, 32'h77);
        mem_rdy = 1; mem_rdata = 16'h0F0F;
        tick();
        tick();
        chk("rst_fresh_ack2", ack_2, 1);
        chk("rst_fresh_rdata2", rdata_2, 32'h0F0F);
        chk("rst_fresh_err2", err_2, 0);
        mem_rdy = 0; req_2 = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
